// File: rtl/pmem_responder.sv
// pmem_responder: slave end of the 256-bit line pmem interface.
// Each request is answered after a fixed LATENCY with a one-cycle pmem_resp pulse.
module pmem_responder #(
    parameter int LINES   = 256,
    parameter int LATENCY = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [31:0]  pmem_address,
    input  logic [255:0] pmem_wdata,
    output logic         pmem_resp,
    output logic [255:0] pmem_rdata,
    output logic         busy,
    output logic         proto_err
);

    localparam int IW = $clog2(LINES);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP,
        GAP
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [CW-1:0]  counter;
    logic           op_write;
    logic [IW-1:0]  op_idx;
    logic [255:0]   op_wdata;
    logic [255:0]   store [LINES];

    logic           accept;
    logic           exec_en;
    logic           exec_write;
    logic [IW-1:0]  exec_idx;
    logic [255:0]   exec_wdata;
    logic [IW-1:0]  req_idx;
    logic           unused_addr_bits;

    assign req_idx          = pmem_address[5+IW-1:5];
    assign unused_addr_bits = ^{pmem_address[31:5+IW], pmem_address[4:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // With LATENCY=1 the operation executes on the acceptance edge, so it
    // must come straight from the inputs rather than the capture registers.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        exec_en    = 1'b0;
        exec_write = op_write;
        exec_idx   = op_idx;
        exec_wdata = op_wdata;
        case (state)
            IDLE: begin
                if (pmem_read || pmem_write) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        next_state = RESP;
                        exec_en    = 1'b1;
                        exec_write = pmem_write;
                        exec_idx   = req_idx;
                        exec_wdata = pmem_wdata;
                    end else begin
                        next_state = BUSY;
                    end
                end
            end
            BUSY: begin
                if (counter == CW'(1)) begin
                    next_state = RESP;
                    exec_en    = 1'b1;
                end
            end
            RESP:    next_state = GAP;
            GAP:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter <= '0;
        end else if (accept) begin
            counter <= CW'(LATENCY - 1);
        end else if (state == BUSY) begin
            counter <= counter - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_write <= 1'b0;
            op_idx   <= '0;
            op_wdata <= '0;
        end else if (accept) begin
            op_write <= pmem_write;
            op_idx   <= req_idx;
            op_wdata <= pmem_wdata;
        end
    end

    // The backing store is deliberately not reset.
    always_ff @(posedge clk) begin
        if (exec_en && exec_write) begin
            store[exec_idx] <= exec_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pmem_rdata <= '0;
        end else if (exec_en && !exec_write) begin
            pmem_rdata <= store[exec_idx];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            proto_err <= 1'b0;
        end else if (accept && pmem_read && pmem_write) begin
            proto_err <= 1'b1;
        end
    end

    assign pmem_resp = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: one instance at LATENCY=4, one at LATENCY=1.
module tb_pmem_responder;

    localparam int LAT0 = 4;
    localparam int LAT1 = 1;

    typedef struct {
        int unsigned  cyc;
        logic [255:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;
    logic         busy;
    logic         proto_err;

    logic         reset1_n;
    logic         rd1;
    logic         wr1;
    logic [31:0]  addr1;
    logic [255:0] wdata1;
    logic         resp1;
    logic [255:0] rdata1;
    logic         busy1;
    logic         perr1;

    int unsigned  cyc = 0;
    int           checks = 0;
    int           errors = 0;
    exp_t         q0[$];
    exp_t         q1[$];
    exp_t         mon_e0;
    exp_t         mon_e1;

    pmem_responder #(.LINES(256), .LATENCY(LAT0)) dut (
        .clk(clk), .reset_n(reset_n), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp),
        .pmem_rdata(pmem_rdata), .busy(busy), .proto_err(proto_err)
    );

    pmem_responder #(.LINES(256), .LATENCY(LAT1)) dut1 (
        .clk(clk), .reset_n(reset1_n), .pmem_read(rd1), .pmem_write(wr1),
        .pmem_address(addr1), .pmem_wdata(wdata1), .pmem_resp(resp1),
        .pmem_rdata(rdata1), .busy(busy1), .proto_err(perr1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flagTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timeout waiting for DUT", name);
    endtask

    // Monitors pop one expectation per response pulse; a pulse with nothing
    // outstanding is itself an error (double accept, aborted op responding).
    always @(negedge clk) begin
        if (pmem_resp === 1'b1) begin
            if (q0.size() == 0) begin
                flagTimeout("unexpected_resp0");
            end else begin
                mon_e0 = q0.pop_front();
                checkOutput("resp0_cycle", 256'(cyc), 256'(mon_e0.cyc));
                checkOutput("resp0_rdata", pmem_rdata, mon_e0.data);
            end
        end
    end

    always @(negedge clk) begin
        if (resp1 === 1'b1) begin
            if (q1.size() == 0) begin
                flagTimeout("unexpected_resp1");
            end else begin
                mon_e1 = q1.pop_front();
                checkOutput("resp1_cycle", 256'(cyc), 256'(mon_e1.cyc));
                checkOutput("resp1_rdata", rdata1, mon_e1.data);
            end
        end
    end

    task automatic waitIdle0();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) flagTimeout("idle0");
    endtask

    task automatic waitIdle1();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy1 === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) flagTimeout("idle1");
    endtask

    // One held request on the LATENCY=4 instance; dropped once pmem_resp is seen.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [255:0] wdata, input logic [255:0] exp_rdata);
        exp_t e;
        bit   seen = 1'b0;
        waitIdle0();
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wdata;
        e.cyc  = cyc + LAT0;
        e.data = exp_rdata;
        q0.push_back(e);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) checkOutput("busy_after_accept", 256'(busy), 256'd1);
            if (pmem_resp === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) flagTimeout("resp0_wait");
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   nresp;
        bit   gap_checked;

        reset_n = 1'b1; reset1_n = 1'b0;
        pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0; pmem_wdata = '0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;

        #2 reset_n = 1'b0;
        #1;
        checkOutput("reset_resp", 256'(pmem_resp), 256'd0);
        checkOutput("reset_rdata", pmem_rdata, 256'd0);
        checkOutput("reset_busy", 256'(busy), 256'd0);
        checkOutput("reset_proto_err", 256'(proto_err), 256'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n  = 1'b1;
        reset1_n = 1'b1;

        applyStimulus(1'b0, 1'b1, 32'h0000_0040, {8{32'hDEADBEEF}}, 256'd0);
        applyStimulus(1'b1, 1'b0, 32'h0000_005C, '0, {8{32'hDEADBEEF}});
        applyStimulus(1'b0, 1'b1, 32'h0000_2040, {8{32'h12345678}}, {8{32'hDEADBEEF}});
        applyStimulus(1'b1, 1'b0, 32'h0000_0040, '0, {8{32'h12345678}});
        checkOutput("wrap_no_proto_err", 256'(proto_err), 256'd0);

        applyStimulus(1'b1, 1'b1, 32'h0000_0080, {8{32'hA5A5A5A5}}, {8{32'h12345678}});
        checkOutput("proto_err_set", 256'(proto_err), 256'd1);
        applyStimulus(1'b1, 1'b0, 32'h0000_0080, '0, {8{32'hA5A5A5A5}});
        checkOutput("proto_err_sticky", 256'(proto_err), 256'd1);

        // Abort a write in BUSY; no expectation is queued so any pulse fails.
        waitIdle0();
        pmem_write   = 1'b1;
        pmem_address = 32'h0000_0080;
        pmem_wdata   = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_busy", 256'(busy), 256'd0);
        checkOutput("abort_resp", 256'(pmem_resp), 256'd0);
        checkOutput("abort_proto_err", 256'(proto_err), 256'd0);
        checkOutput("abort_rdata", pmem_rdata, 256'd0);
        pmem_write = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0000_0080, '0, {8{32'hA5A5A5A5}});

        // LATENCY=1 instance: write a line, then hold a read across two responses.
        waitIdle1();
        wr1    = 1'b1;
        addr1  = 32'h0000_0040;
        wdata1 = {8{32'h0F0F0F0F}};
        e.cyc  = cyc + LAT1;
        e.data = 256'd0;
        q1.push_back(e);
        nresp = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp1 === 1'b1) begin
                nresp = 1;
                break;
            end
        end
        if (nresp == 0) flagTimeout("resp1_write_wait");
        wr1 = 1'b0;

        waitIdle1();
        rd1    = 1'b1;
        e.cyc  = cyc + LAT1;
        e.data = {8{32'h0F0F0F0F}};
        q1.push_back(e);
        e.cyc  = cyc + LAT1 + 3;
        q1.push_back(e);
        nresp = 0;
        gap_checked = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (nresp == 1 && !gap_checked) begin
                gap_checked = 1'b1;
                checkOutput("gap_busy1", 256'(busy1), 256'd1);
                checkOutput("gap_resp1", 256'(resp1), 256'd0);
            end
            if (resp1 === 1'b1) nresp++;
            if (nresp == 2) break;
        end
        if (nresp != 2) flagTimeout("resp1_read_wait");
        rd1 = 1'b0;
        repeat (6) @(negedge clk);

        checkOutput("q0_drained", 256'(q0.size()), 256'd0);
        checkOutput("q1_drained", 256'(q1.size()), 256'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
